// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage that turns EX/MEM load/store ops into dmem requests and fills MEM/WB.
//
// Ports
//   clk, reset_n              clock (rising edge) and asynchronous active-low reset
//   ex_mem_*                  EX/MEM register fields and control; held stable while mem_stall=1
//   dmem_req_valid/ready      request handshake; dmem_we/addr/wdata/wstrb are the request payload
//   dmem_rsp_valid/rdata      read/write response, only honoured while waiting for one
//   mem_wb_*                  registered MEM/WB fields (bubble on stalled, aborted or rejected edges)
//   mem_stall                 freezes upstream while a memory op is pending and not completing
//   bus_err                   one-cycle pulse in the cycle a pending op is aborted by timeout
//   misalign_err              one-cycle pulse for a rejected misaligned op
//
// Parameter TIMEOUT_CYCLES (1..255): the op is aborted in its TIMEOUT_CYCLES-th cycle in REQ/WAIT.
// Define MEM_ACCESS_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses; without it they
// are issued as-is and lanes past bit 31 are dropped.
module mem_access #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] ex_mem_alu_result,
   input  logic [31:0] ex_mem_rs2_data,
   input  logic [4:0]  ex_mem_rd,
   input  logic        ex_mem_RegWrite,
   input  logic        ex_mem_MemRead,
   input  logic        ex_mem_MemWrite,
   input  logic        ex_mem_MemToReg,
   input  logic [2:0]  ex_mem_funct3,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] mem_wb_alu_result,
   output logic [31:0] mem_wb_mem_data,
   output logic [4:0]  mem_wb_rd,
   output logic        mem_wb_RegWrite,
   output logic        mem_wb_MemToReg,
   output logic        mem_stall,
   output logic        bus_err,
   output logic        misalign_err
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   state_t state, state_nx;
   logic [7:0] cnt;
   logic [1:0] off;
   logic [31:0] lane, load_data;
   logic mem_op, misalign, issue, done, tmo, wr, sx;
   assign mem_op = ex_mem_MemRead | ex_mem_MemWrite;
   assign off = ex_mem_alu_result[1:0];
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
   // funct3[1:0]: 00 byte, 01 half, 1x word
   assign misalign = mem_op && ((ex_mem_funct3[1:0] == 2'b01 && off[0]) || (ex_mem_funct3[1] && off != 2'b00));
`else
   assign misalign = 1'b0;
`endif
   assign issue = state == IDLE && mem_op && !misalign;
   assign done = state == WAIT && dmem_rsp_valid;
   // a response landing in the timeout cycle wins over the abort
   assign tmo = state != IDLE && !done && cnt == TMO_LAST;
   assign wr = (state == IDLE && !mem_op) || done;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (issue) state_nx = dmem_req_ready ? WAIT : REQ;
         REQ:     if (tmo) state_nx = IDLE; else if (dmem_req_ready) state_nx = WAIT;
         WAIT:    if (done || tmo) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // input-driven outputs are masked so they read 0 while reset is held
   assign dmem_req_valid = reset_n && (issue || state == REQ);
   assign mem_stall = reset_n && (issue || (state != IDLE && !done && !tmo));
   assign misalign_err = reset_n && state == IDLE && misalign;
   assign bus_err = tmo;
   assign dmem_we = ex_mem_MemWrite;
   assign dmem_addr = ex_mem_alu_result;
   assign dmem_wdata = ex_mem_funct3[1:0] == 2'b00 ? {4{ex_mem_rs2_data[7:0]}}
                     : ex_mem_funct3[1:0] == 2'b01 ? {2{ex_mem_rs2_data[15:0]}} : ex_mem_rs2_data;
   assign dmem_wstrb = !ex_mem_MemWrite ? 4'b0000
                     : ex_mem_funct3[1:0] == 2'b00 ? 4'b0001 << off
                     : ex_mem_funct3[1:0] == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
   assign sx = ~ex_mem_funct3[2];
   assign lane = dmem_rdata >> {off, 3'b000};
   assign load_data = ex_mem_funct3[1:0] == 2'b00 ? {{24{sx & lane[7]}}, lane[7:0]}
                    : ex_mem_funct3[1:0] == 2'b01 ? {{16{sx & lane[15]}}, lane[15:0]} : lane;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         cnt <= 8'd0;
         mem_wb_alu_result <= 32'd0;
         mem_wb_mem_data <= 32'd0;
         mem_wb_rd <= 5'd0;
         mem_wb_RegWrite <= 1'b0;
         mem_wb_MemToReg <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= (state != IDLE && state_nx != IDLE) ? cnt + 8'd1 : 8'd0;
         mem_wb_alu_result <= wr ? ex_mem_alu_result : 32'd0;
         mem_wb_mem_data <= (done && !ex_mem_MemWrite) ? load_data : 32'd0;
         mem_wb_rd <= wr ? ex_mem_rd : 5'd0;
         mem_wb_RegWrite <= wr && ex_mem_RegWrite && !ex_mem_MemWrite;
         mem_wb_MemToReg <= wr && ex_mem_MemToReg;
      end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles from request to response before abort (8-bit counter).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ex_mem_alu_result/ex_mem_rs2_data  input  32 each, and ex_mem_rd  input  5; these are the EX/MEM register fields.
REQ-005 SHALL have ports ex_mem_RegWrite/MemRead/MemWrite/MemToReg  input  1 each, and ex_mem_funct3  input  3; these are the EX/MEM control fields.
REQ-006 SHALL have ports dmem_req_valid  output  1, dmem_req_ready  input  1, dmem_we  output  1, dmem_addr  output  32, dmem_wdata  output  32, dmem_wstrb  output  4.
REQ-007 SHALL have ports dmem_rsp_valid  input  1 and dmem_rdata  input  32.
REQ-008 SHALL have ports mem_wb_alu_result/mem_data  output  32 each, mem_wb_rd  output  5, mem_wb_RegWrite/MemToReg  output  1 each; these are registered MEM/WB fields.
REQ-009 SHALL have ports mem_stall  output  1 (freeze upstream), bus_err  output  1, misalign_err  output  1.

Function
REQ-010 SHALL treat an op as a memory op when MemRead|MemWrite; MemWrite wins if both are set.
REQ-011 SHALL capture a non-memory op into MEM/WB at the next edge without stalling: alu_result, rd, RegWrite and MemToReg pass through, and mem_data = 0.
REQ-012 SHALL implement FSM states IDLE, REQ and WAIT.
REQ-013 SHALL, in IDLE with a memory op, drive dmem_req_valid=1 combinationally; if dmem_req_ready=1, go to WAIT, else go to REQ.
REQ-014 SHALL, in REQ, hold dmem_req_valid and all dmem_* outputs stable until dmem_req_ready=1, then go to WAIT.
REQ-015 SHALL, in WAIT, on dmem_rsp_valid=1, write MEM/WB at that edge (loads: formatted data; stores: RegWrite forced 0), deassert mem_stall in that cycle, and return to IDLE.
REQ-016 SHALL hold mem_stall=1 in every cycle a memory op is pending and not completing; ex_mem_* inputs SHALL be stable while mem_stall=1.
REQ-017 SHALL write a bubble (RegWrite=0, MemToReg=0, rd=0) into MEM/WB on each stalled edge.
REQ-018 SHALL give a minimum memory-op latency of 2 cycles: request accepted in cycle N, response in N+1.
REQ-019 SHALL drive dmem_addr = alu_result, dmem_we = MemWrite, and dmem_wdata = rs2_data replicated (byte x4 for SB, half x2 for SH, word for SW).
REQ-020 SHALL drive dmem_wstrb = 0001 shifted left by addr[1:0] for SB, 0011 shifted left by addr[1] x2 for SH, 1111 for SW, and 0000 for loads.
REQ-021 SHALL format load data using the lane selected by addr[1:0]: funct3 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend, other codes as LW.
REQ-022 SHALL count cycles spent in REQ/WAIT; when the count reaches TIMEOUT_CYCLES, it SHALL pulse bus_err for 1 cycle, write a bubble, drop mem_stall and return to IDLE.
REQ-023 SHALL give a response that coincides with the timeout cycle priority, so the op completes normally and bus_err stays 0.
REQ-024 SHALL ignore dmem_rsp_valid outside WAIT.

Reset
REQ-025 SHALL, on reset_n low, asynchronously reset: FSM to IDLE, counter to 0, all mem_wb_* to 0, and mem_stall, bus_err, misalign_err, dmem_req_valid to 0.
REQ-026 SHALL abandon any in-flight request on reset mid-operation; a later response SHALL be ignored per REQ-024.

Configuration
REQ-027 SHALL use macro MEM_ACCESS_MISALIGN_CHECK_EN to enable the misalignment check.
REQ-028 SHALL, with the macro defined, treat LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 as follows: no request, misalign_err pulses for 1 cycle, bubble written, no stall.
REQ-029 SHALL, without the macro, tie misalign_err to 0 and issue misaligned accesses as-is, truncating lanes beyond bit 31.

Verification
REQ-030 SHALL cover: ADD result 0x10, rd=5, RegWrite=1 -> next edge mem_wb_alu_result=0x10, rd=5, RegWrite=1, mem_stall never 1.
REQ-031 SHALL cover: LB at addr 0x103 with ready=1 and rsp next cycle, rdata=0x80FFFFFF -> mem_data=0xFFFFFF80, MemToReg=1, stall exactly 1 cycle.
REQ-032 SHALL cover: SH at addr 0x102 with rs2=0x1234 and ready held 0 for 3 cycles -> dmem_wstrb=1100, wdata=0x12341234 stable for 3 cycles, then WAIT, mem_wb_RegWrite=0.
REQ-033 SHALL cover: LW with TIMEOUT_CYCLES=4 and no response -> bus_err single pulse after 4 pending cycles, mem_stall low the following cycle, bubble written.
REQ-034 SHALL cover: reset_n low during WAIT, then response arrives -> all outputs 0, FSM IDLE, response ignored.
REQ-035 SHALL cover, with the macro defined: LW at addr 0x102 -> misalign_err=1 for 1 cycle, dmem_req_valid stays 0, mem_wb_RegWrite=0.
